// File: rtl/pattern_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// pattern_port_arbiter_pkg
// Shared PPU definitions used by the pattern-port arbiter and its ID FIFO.
//   PAT_ADDR_W  : width of a pattern-table address
//   pixel_t     : one 2-bit pixel; a pattern row is pixel_t [7:0]
//   arbState_t  : arbiter operating mode (normal traffic / draining after clear)
// ---------------------------------------------------------------------------
package pattern_port_arbiter_pkg;

   localparam int PAT_ADDR_W = 13;

   typedef logic [1:0] pixel_t;

   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } arbState_t;

endpackage

// File: rtl/pattern_port_arbiter_req_id_fifo.sv
// ---------------------------------------------------------------------------
// req_id_fifo
// Small FIFO holding the requester ID of every outstanding memory read, so
// that in-order returns can be routed back to whoever issued them.
// Ports:
//   clock, reset   : rising-edge clock, asynchronous active-high reset
//   push_i, wrData_i : enqueue an ID (ignored when full)
//   pop_i          : dequeue the head (ignored when empty)
//   flush_i        : empty the FIFO; overrides push and pop
//   rdData_o       : current head ID
//   full_o, empty_o, count_o : occupancy status
// ---------------------------------------------------------------------------
module req_id_fifo #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wrData_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   output logic [WIDTH-1:0]         rdData_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
   logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             doPush;
   logic             doPop;

   assign full_o   = (count_q == CNT_W'(DEPTH));
   assign empty_o  = (count_q == '0);
   assign count_o  = count_q;
   assign rdData_o = mem_q[rdPtr_q];
   assign doPush   = push_i && !full_o && !flush_i;
   assign doPop    = pop_i && !empty_o && !flush_i;

   // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths also work.
   // A simultaneous push and pop leaves the occupancy unchanged.
   always_comb begin
      rdPtr_d = rdPtr_q;
      wrPtr_d = wrPtr_q;
      count_d = count_q;
      if (flush_i) begin
         rdPtr_d = '0;
         wrPtr_d = '0;
         count_d = '0;
      end else begin
         if (doPush) begin
            wrPtr_d = (wrPtr_q == PTR_W'(DEPTH - 1)) ? '0 : wrPtr_q + 1'b1;
         end
         if (doPop) begin
            rdPtr_d = (rdPtr_q == PTR_W'(DEPTH - 1)) ? '0 : rdPtr_q + 1'b1;
         end
         if (doPush && !doPop) begin
            count_d = count_q + 1'b1;
         end else if (doPop && !doPush) begin
            count_d = count_q - 1'b1;
         end
      end
   end

   // Occupancy bookkeeping; reset empties the FIFO.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rdPtr_q <= '0;
         wrPtr_q <= '0;
         count_q <= '0;
      end else begin
         rdPtr_q <= rdPtr_d;
         wrPtr_q <= wrPtr_d;
         count_q <= count_d;
      end
   end

   // ID storage needs no reset: entries are only read while the FIFO is non-empty.
   always_ff @(posedge clock) begin
      if (doPush) begin
         mem_q[wrPtr_q] <= wrData_i;
      end
   end

endmodule

// File: rtl/pattern_port_arbiter.sv
// ---------------------------------------------------------------------------
// pattern_port_arbiter
// Round-robin arbiter sharing one pattern-memory read port between NUM_REQ
// requesters (requester 0 is the sprite manager). Grants are combinational
// and drive the memory strobe in the same cycle; in-order returns are routed
// back to the issuing requester with zero latency using an ID FIFO. A
// line-start clear flushes everything and drains reads still in flight.
// Ports:
//   clock, reset            : rising-edge clock, asynchronous active-high reset
//   clear                   : synchronous line-start flush
//   req_read, req_addr      : per-requester request and pattern address
//   req_grant               : one-hot, request accepted this cycle
//   req_data, req_avail     : returned row and one-hot owner strobe
//   mem_read, mem_addr      : memory read strobe and address
//   mem_ready               : memory accepts a read this cycle
//   mem_data, mem_avail     : in-order memory return
//   err_orphan              : sticky flag, a return arrived with nothing pending
// ---------------------------------------------------------------------------
module pattern_port_arbiter
   import pattern_port_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int DEPTH   = 4
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic                                clear,
   input  logic [NUM_REQ-1:0]                  req_read,
   input  logic [NUM_REQ-1:0][PAT_ADDR_W-1:0]  req_addr,
   output logic [NUM_REQ-1:0]                  req_grant,
   output pixel_t [7:0]                        req_data,
   output logic [NUM_REQ-1:0]                  req_avail,
   output logic                                mem_read,
   output logic [PAT_ADDR_W-1:0]               mem_addr,
   input  logic                                mem_ready,
   input  pixel_t [7:0]                        mem_data,
   input  logic                                mem_avail,
   output logic                                err_orphan
);

   localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   arbState_t        state_q, state_d;
   logic [ID_W-1:0]  rrPtr_q, rrPtr_d;
   logic [CNT_W-1:0] drainCnt_q, drainCnt_d;
   logic             errOrphan_q, errOrphan_d;

   logic             grantValid;
   logic [ID_W-1:0]  grantIdx;
   logic [ID_W:0]    cand;

   logic             fifoPush;
   logic             fifoPop;
   logic             fifoFlush;
   logic             fifoFull;
   logic             fifoEmpty;
   logic [CNT_W-1:0] fifoCount;
   logic [ID_W-1:0]  fifoHead;

   req_id_fifo #(
      .WIDTH (ID_W),
      .DEPTH (DEPTH)
   ) idFifo (
      .clock    (clock),
      .reset    (reset),
      .push_i   (fifoPush),
      .wrData_i (grantIdx),
      .pop_i    (fifoPop),
      .flush_i  (fifoFlush),
      .rdData_o (fifoHead),
      .full_o   (fifoFull),
      .empty_o  (fifoEmpty),
      .count_o  (fifoCount)
   );

   // Round-robin search: walk the requesters starting at rrPtr and take the
   // first one asserting req_read. The candidate index is one bit wider so the
   // wrap past NUM_REQ-1 can be folded back with a single subtraction.
   always_comb begin
      grantValid = 1'b0;
      grantIdx   = '0;
      cand       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, rrPtr_q} + (ID_W + 1)'(k);
         if (cand >= (ID_W + 1)'(NUM_REQ)) begin
            cand = cand - (ID_W + 1)'(NUM_REQ);
         end
         if (!grantValid && req_read[cand[ID_W-1:0]]) begin
            grantValid = 1'b1;
            grantIdx   = cand[ID_W-1:0];
         end
      end
   end

   // Main control. In RUN a grant needs memory ready and a non-full FIFO; a
   // full FIFO blocks even if a return pops it this cycle, which keeps the
   // grant path independent of mem_avail. Clear flushes the FIFO and counts
   // the reads still in flight (minus one returning right now) so they can be
   // swallowed in DRAIN without reaching any requester. All requester- and
   // memory-facing strobes are forced low while reset is held.
   always_comb begin
      state_d     = state_q;
      rrPtr_d     = rrPtr_q;
      drainCnt_d  = drainCnt_q;
      errOrphan_d = errOrphan_q;
      req_grant   = '0;
      req_avail   = '0;
      req_data    = '0;
      mem_read    = 1'b0;
      mem_addr    = '0;
      fifoPush    = 1'b0;
      fifoPop     = 1'b0;
      fifoFlush   = 1'b0;

      case (state_q)
         RUN: begin
            if (clear) begin
               fifoFlush   = 1'b1;
               rrPtr_d     = '0;
               errOrphan_d = 1'b0;
               if (mem_avail && !fifoEmpty) begin
                  drainCnt_d = fifoCount - 1'b1;
               end else begin
                  drainCnt_d = fifoCount;
               end
               state_d = (drainCnt_d != '0) ? DRAIN : RUN;
            end else begin
               if (grantValid && mem_ready && !fifoFull) begin
                  req_grant[grantIdx] = 1'b1;
                  mem_read            = 1'b1;
                  mem_addr            = req_addr[grantIdx];
                  fifoPush            = 1'b1;
                  rrPtr_d = (int'(grantIdx) == NUM_REQ - 1) ? '0 : grantIdx + 1'b1;
               end
               if (mem_avail) begin
                  if (!fifoEmpty) begin
                     fifoPop             = 1'b1;
                     req_avail[fifoHead] = 1'b1;
                     req_data            = mem_data;
                  end else begin
                     errOrphan_d = 1'b1;
                  end
               end
            end
         end

         DRAIN: begin
            if (clear) begin
               errOrphan_d = 1'b0;
            end
            if (mem_avail && drainCnt_q != '0) begin
               drainCnt_d = drainCnt_q - 1'b1;
            end
            if (drainCnt_d == '0) begin
               state_d = RUN;
            end
         end

         default: begin
            state_d = RUN;
         end
      endcase

      if (reset) begin
         req_grant = '0;
         req_avail = '0;
         req_data  = '0;
         mem_read  = 1'b0;
         mem_addr  = '0;
      end
   end

   // State registers; reset returns to RUN with an empty pipeline.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= RUN;
         rrPtr_q     <= '0;
         drainCnt_q  <= '0;
         errOrphan_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rrPtr_q     <= rrPtr_d;
         drainCnt_q  <= drainCnt_d;
         errOrphan_q <= errOrphan_d;
      end
   end

   assign err_orphan = errOrphan_q;

endmodule

// File: tb/tb_pattern_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pattern_port_arbiter
// Self-checking bench: a hand-computed vector table, short directed
// sequences for clear/drain, orphan and reset behaviour, then random traffic
// compared against a queue-based behavioural model of the arbiter.
// ---------------------------------------------------------------------------
module tb_pattern_port_arbiter;
   import pattern_port_arbiter_pkg::*;

   localparam int NUM_REQ = 2;
   localparam int DEPTH   = 4;

   logic                               clock;
   logic                               reset;
   logic                               clear;
   logic [NUM_REQ-1:0]                 req_read;
   logic [NUM_REQ-1:0][PAT_ADDR_W-1:0] req_addr;
   logic [NUM_REQ-1:0]                 req_grant;
   pixel_t [7:0]                       req_data;
   logic [NUM_REQ-1:0]                 req_avail;
   logic                               mem_read;
   logic [PAT_ADDR_W-1:0]              mem_addr;
   logic                               mem_ready;
   pixel_t [7:0]                       mem_data;
   logic                               mem_avail;
   logic                               err_orphan;

   int checks;
   int errors;

   logic [NUM_REQ-1:0] lastGrant;
   logic [NUM_REQ-1:0] lastAvail;
   logic               lastOrphan;

   // Behavioural model: pending IDs in issue order, round-robin start,
   // drain mode with its remaining count, and the sticky orphan flag.
   int mQ[$];
   int mRr;
   bit mDrain;
   int mDrainCnt;
   bit mOrphan;

   typedef struct {
      logic [1:0] rr;
      logic       ready;
      logic       avail;
      logic       clr;
      logic [1:0] eGrant;
      logic [1:0] eAvail;
      logic       eOrphan;
   } vec_t;

   vec_t tbl[21];

   pattern_port_arbiter #(
      .NUM_REQ (NUM_REQ),
      .DEPTH   (DEPTH)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .clear      (clear),
      .req_read   (req_read),
      .req_addr   (req_addr),
      .req_grant  (req_grant),
      .req_data   (req_data),
      .req_avail  (req_avail),
      .mem_read   (mem_read),
      .mem_addr   (mem_addr),
      .mem_ready  (mem_ready),
      .mem_data   (mem_data),
      .mem_avail  (mem_avail),
      .err_orphan (err_orphan)
   );

   // Free-running 10-time-unit clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic modelReset();
      mQ.delete();
      mRr       = 0;
      mDrain    = 1'b0;
      mDrainCnt = 0;
      mOrphan   = 1'b0;
   endtask

   task automatic doReset();
      reset     = 1'b1;
      clear     = 1'b0;
      req_read  = '0;
      req_addr  = '0;
      mem_ready = 1'b0;
      mem_avail = 1'b0;
      mem_data  = '0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      modelReset();
   endtask

   // One clock cycle: drive inputs just after the edge, check the outputs
   // mid-cycle against the model, then let the model follow the edge.
   task automatic applyStimulus(input logic [1:0] rr, input logic ready, input logic avail, input logic clr);
      int g;
      int cand;
      int n;
      logic [NUM_REQ-1:0] eGrant;
      logic [NUM_REQ-1:0] eAvail;
      logic [15:0] eData;
      logic [PAT_ADDR_W-1:0] eAddr;

      req_read    = rr;
      mem_ready   = ready;
      mem_avail   = avail;
      clear       = clr;
      req_addr[0] = 13'($urandom);
      req_addr[1] = 13'($urandom);
      mem_data    = 16'($urandom);
      #4;

      g      = -1;
      eGrant = '0;
      eAvail = '0;
      eData  = '0;
      eAddr  = '0;
      if (!mDrain && !clr && ready && mQ.size() < DEPTH) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            cand = (mRr + k) % NUM_REQ;
            if (g < 0 && rr[cand]) g = cand;
         end
      end
      if (g >= 0) begin
         eGrant[g] = 1'b1;
         eAddr     = req_addr[g];
      end
      if (!mDrain && !clr && avail && mQ.size() > 0) begin
         eAvail[mQ[0]] = 1'b1;
         eData         = 16'(mem_data);
      end

      lastGrant  = req_grant;
      lastAvail  = req_avail;
      lastOrphan = err_orphan;
      checkOutput("req_grant",  32'(req_grant),       32'(eGrant));
      checkOutput("req_avail",  32'(req_avail),       32'(eAvail));
      checkOutput("mem_read",   32'(mem_read),        32'(g >= 0));
      checkOutput("mem_addr",   32'(mem_addr),        32'(eAddr));
      checkOutput("req_data",   32'(16'(req_data)),   32'(eData));
      checkOutput("err_orphan", 32'(err_orphan),      32'(mOrphan));

      if (!mDrain) begin
         if (clr) begin
            n = mQ.size() - (avail ? 1 : 0);
            if (n < 0) n = 0;
            mQ.delete();
            mRr     = 0;
            mOrphan = 1'b0;
            if (n > 0) begin
               mDrain    = 1'b1;
               mDrainCnt = n;
            end
         end else begin
            if (avail) begin
               if (mQ.size() > 0) void'(mQ.pop_front());
               else mOrphan = 1'b1;
            end
            if (g >= 0) begin
               mQ.push_back(g);
               mRr = (g + 1) % NUM_REQ;
            end
         end
      end else begin
         if (clr) mOrphan = 1'b0;
         if (avail) begin
            mDrainCnt--;
            if (mDrainCnt == 0) mDrain = 1'b0;
         end
      end

      @(posedge clock);
      #1;
   endtask

   initial begin
      logic [15:0] dataVal;
      logic [PAT_ADDR_W-1:0] expAddr;

      checks = 0;
      errors = 0;

      // Alternating grants with 2-cycle returns, fill to DEPTH, pop-cycle
      // block, drain to empty, orphan, clear, mem_ready low, post-clear rr.
      tbl[0]  = '{2'b11, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0};
      tbl[1]  = '{2'b11, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0};
      tbl[2]  = '{2'b11, 1'b1, 1'b1, 1'b0, 2'b01, 2'b01, 1'b0};
      tbl[3]  = '{2'b11, 1'b1, 1'b1, 1'b0, 2'b10, 2'b10, 1'b0};
      tbl[4]  = '{2'b11, 1'b1, 1'b1, 1'b0, 2'b01, 2'b01, 1'b0};
      tbl[5]  = '{2'b11, 1'b1, 1'b1, 1'b0, 2'b10, 2'b10, 1'b0};
      tbl[6]  = '{2'b11, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0};
      tbl[7]  = '{2'b11, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0};
      tbl[8]  = '{2'b11, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
      tbl[9]  = '{2'b11, 1'b1, 1'b1, 1'b0, 2'b00, 2'b01, 1'b0};
      tbl[10] = '{2'b11, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0};
      tbl[11] = '{2'b11, 1'b1, 1'b1, 1'b0, 2'b00, 2'b10, 1'b0};
      tbl[12] = '{2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 2'b01, 1'b0};
      tbl[13] = '{2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 2'b10, 1'b0};
      tbl[14] = '{2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 2'b01, 1'b0};
      tbl[15] = '{2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0};
      tbl[16] = '{2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1};
      tbl[17] = '{2'b00, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1};
      tbl[18] = '{2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
      tbl[19] = '{2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
      tbl[20] = '{2'b11, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0};

      doReset();
      #3;
      checkOutput("reset grant",  32'(req_grant),  32'd0);
      checkOutput("reset avail",  32'(req_avail),  32'd0);
      checkOutput("reset memrd",  32'(mem_read),   32'd0);
      checkOutput("reset orphan", 32'(err_orphan), 32'd0);
      @(posedge clock);
      #1;

      for (int i = 0; i < 21; i++) begin
         req_read    = tbl[i].rr;
         mem_ready   = tbl[i].ready;
         mem_avail   = tbl[i].avail;
         clear       = tbl[i].clr;
         req_addr[0] = 13'h0123;
         req_addr[1] = 13'h1456;
         dataVal     = 16'($urandom);
         mem_data    = dataVal;
         #4;
         expAddr = tbl[i].eGrant[0] ? 13'h0123 : (tbl[i].eGrant[1] ? 13'h1456 : 13'h0000);
         checkOutput($sformatf("tbl[%0d] grant", i),  32'(req_grant),     32'(tbl[i].eGrant));
         checkOutput($sformatf("tbl[%0d] avail", i),  32'(req_avail),     32'(tbl[i].eAvail));
         checkOutput($sformatf("tbl[%0d] memrd", i),  32'(mem_read),      32'(tbl[i].eGrant != 2'b00));
         checkOutput($sformatf("tbl[%0d] addr", i),   32'(mem_addr),      32'(expAddr));
         checkOutput($sformatf("tbl[%0d] data", i),   32'(16'(req_data)), (tbl[i].eAvail != 2'b00) ? 32'(dataVal) : 32'd0);
         checkOutput($sformatf("tbl[%0d] orphan", i), 32'(err_orphan),    32'(tbl[i].eOrphan));
         @(posedge clock);
         #1;
      end

      // Clear with three reads outstanding and no return in that cycle.
      doReset();
      repeat (3) applyStimulus(2'b11, 1'b1, 1'b0, 1'b0);
      applyStimulus(2'b11, 1'b1, 1'b0, 1'b1);
      applyStimulus(2'b11, 1'b1, 1'b1, 1'b0);
      checkOutput("drain ret1 avail", 32'(lastAvail), 32'd0);
      checkOutput("drain ret1 grant", 32'(lastGrant), 32'd0);
      applyStimulus(2'b11, 1'b1, 1'b0, 1'b0);
      applyStimulus(2'b11, 1'b1, 1'b1, 1'b0);
      applyStimulus(2'b11, 1'b1, 1'b1, 1'b0);
      checkOutput("drain ret3 avail", 32'(lastAvail), 32'd0);
      checkOutput("drain ret3 grant", 32'(lastGrant), 32'd0);
      applyStimulus(2'b11, 1'b1, 1'b0, 1'b0);
      checkOutput("after drain grant", 32'(lastGrant), 32'b01);

      // Clear with one outstanding read returning in the same cycle.
      doReset();
      applyStimulus(2'b01, 1'b1, 1'b0, 1'b0);
      applyStimulus(2'b11, 1'b1, 1'b1, 1'b1);
      checkOutput("clr+ret avail", 32'(lastAvail), 32'd0);
      checkOutput("clr+ret grant", 32'(lastGrant), 32'd0);
      applyStimulus(2'b11, 1'b1, 1'b0, 1'b0);
      checkOutput("clr+ret rr0 grant", 32'(lastGrant), 32'b01);

      // Orphan return sets a sticky flag that only clear removes.
      doReset();
      applyStimulus(2'b00, 1'b1, 1'b1, 1'b0);
      checkOutput("orphan no avail", 32'(lastAvail), 32'd0);
      applyStimulus(2'b00, 1'b1, 1'b0, 1'b0);
      checkOutput("orphan set", 32'(lastOrphan), 32'd1);
      applyStimulus(2'b00, 1'b1, 1'b0, 1'b0);
      checkOutput("orphan held", 32'(lastOrphan), 32'd1);
      applyStimulus(2'b00, 1'b1, 1'b0, 1'b1);
      applyStimulus(2'b00, 1'b1, 1'b0, 1'b0);
      checkOutput("orphan cleared", 32'(lastOrphan), 32'd0);

      // Reset asserted in the middle of traffic.
      doReset();
      applyStimulus(2'b11, 1'b1, 1'b0, 1'b0);
      applyStimulus(2'b11, 1'b1, 1'b0, 1'b0);
      applyStimulus(2'b11, 1'b1, 1'b1, 1'b0);
      req_read  = 2'b11;
      mem_ready = 1'b1;
      mem_avail = 1'b1;
      clear     = 1'b0;
      reset     = 1'b1;
      #1;
      checkOutput("rst mid grant", 32'(req_grant),       32'd0);
      checkOutput("rst mid avail", 32'(req_avail),       32'd0);
      checkOutput("rst mid memrd", 32'(mem_read),        32'd0);
      checkOutput("rst mid data",  32'(16'(req_data)),   32'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      modelReset();
      applyStimulus(2'b11, 1'b1, 1'b0, 1'b0);
      checkOutput("rst first grant", 32'(lastGrant), 32'b01);
      applyStimulus(2'b00, 1'b1, 1'b1, 1'b0);
      applyStimulus(2'b00, 1'b1, 1'b1, 1'b0);
      applyStimulus(2'b00, 1'b1, 1'b0, 1'b0);
      checkOutput("rst stale return orphan", 32'(lastOrphan), 32'd1);

      // Random traffic against the model.
      doReset();
      for (int i = 0; i < 400; i++) begin
         applyStimulus(2'($urandom), $urandom_range(0, 3) != 0,
                       $urandom_range(0, 9) < 4, $urandom_range(0, 31) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
